// File: rtl/nmi_xbar_demux_if.sv
// nmi_xbar_demux_if: NMI request/response bundle, N lanes of valid/ready/rdata
//   master : drives valid, addr, wdata, wstrb; receives ready, rdata
//   slave  : receives valid, addr, wdata, wstrb; drives ready, rdata
interface nmi_xbar_demux_if #(parameter int N = 1);
  logic [N-1:0]    valid;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic [N-1:0]    ready;
  logic [N*32-1:0] rdata;
  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/nmi_xbar_demux.sv
// nmi_xbar_demux: 1-to-SLV_NUM NMI demux with window decode, default-slave error and timeout watchdog
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   m (slave port)   upstream request from the NMI master
//   s (master port)  one-hot request to the SLV_NUM native slaves, addr/wdata/wstrb broadcast
//   err_clr_i        clears the sticky error flag
//   err_o/err_tmo_o/err_addr_o  sticky error, timeout-vs-decode cause, faulting address
module nmi_xbar_demux #(
  parameter int                  SLV_NUM    = 14,
  parameter logic [SLV_NUM*32-1:0] ADDR_BASE = {SLV_NUM{32'h0}},
  parameter logic [SLV_NUM*32-1:0] ADDR_MASK = {SLV_NUM{32'h0}},
  parameter int                  TMO_CYCLES = 1024,
  parameter logic [31:0]         ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  nmi_xbar_demux_if.slave     m,
  nmi_xbar_demux_if.master    s,
  input  logic                err_clr_i,
  output logic                err_o,
  output logic                err_tmo_o,
  output logic [31:0]         err_addr_o
);
  localparam int SW = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam int CW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TMO_CYCLES > 0) ? TMO_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;
  state_t          r_state, w_next;
  logic [SW-1:0]   r_sel, w_sel;
  logic [CW-1:0]   r_cnt;
  logic            r_tmo_err, r_err, r_err_tmo;
  logic [31:0]     r_err_addr;
  logic            w_hit, w_rdy, w_ack, w_tmo;
  logic [31:0]     w_rd;
  // Descending scan so the lowest matching window is the last one written.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = SLV_NUM - 1; i >= 0; i--)
      if ((m.addr & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]) begin
        w_hit = 1'b1;
        w_sel = SW'(i);
      end
  end
  assign w_rdy = s.ready[r_sel];
  assign w_rd  = s.rdata[32*r_sel +: 32];
  assign w_ack = (r_state == ACTIVE) && m.valid && w_rdy;
  assign w_tmo = (TMO_CYCLES != 0) && (r_cnt == TMO_LAST);
  // A master that withdraws valid in ACTIVE aborts silently; ready beats the timeout.
  always_comb begin
    w_next = (r_state == IDLE)   ? (m.valid ? (w_hit ? ACTIVE : ERR) : IDLE)
           : (r_state == ACTIVE) ? ((!m.valid || w_rdy) ? IDLE : (w_tmo ? ERR : ACTIVE))
           : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_tmo_err  <= 1'b0;
      r_err      <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && m.valid && w_hit) begin
        r_sel <= w_sel;
        r_cnt <= '0;
      end else if (r_state == ACTIVE && !w_rdy)
        r_cnt <= r_cnt + 1'b1;
      // ERR entered from ACTIVE can only be a timeout; from IDLE it is a decode miss.
      r_tmo_err <= (r_state == ACTIVE);
      if (r_state == ERR) begin
        r_err      <= 1'b1;
        r_err_tmo  <= r_tmo_err;
        r_err_addr <= m.addr;
      end else if (err_clr_i)
        r_err <= 1'b0;
    end
  end
  assign s.valid    = (r_state == ACTIVE) ? (SLV_NUM'(m.valid) << r_sel) : '0;
  assign s.addr     = m.addr;
  assign s.wdata    = m.wdata;
  assign s.wstrb    = m.wstrb;
  assign m.ready    = (r_state == ERR) || w_ack;
  assign m.rdata    = (r_state == ERR) ? ERR_RDATA : (w_ack ? w_rd : '0);
  assign err_o      = r_err;
  assign err_tmo_o  = r_err_tmo;
  assign err_addr_o = r_err_addr;
endmodule

// File: tb/tb_nmi_xbar_demux.sv
// tb_nmi_xbar_demux: directed plus randomized transactions against a transaction-level model
module tb_nmi_xbar_demux;
  localparam int N = 4;
  localparam int TMO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [N*32-1:0] BASE = {32'h1000_0000, 32'h1000_0300, 32'h2000_0100, 32'h1000_0000};
  localparam logic [N*32-1:0] MASK = {32'hF000_0000, 32'hF000_FF00, 32'hF000_FF00, 32'hF000_FF00};
  logic [31:0] win_base [N] = '{32'h1000_0000, 32'h2000_0100, 32'h1000_0300, 32'h1000_0000};
  logic [31:0] win_mask [N] = '{32'hF000_FF00, 32'hF000_FF00, 32'hF000_FF00, 32'hF000_0000};
  logic clk = 1'b0, rst_n = 1'b0, err_clr = 1'b0;
  logic err, err_tmo;
  logic [31:0] err_addr;
  int checks = 0, errors = 0;
  logic exp_err = 1'b0, exp_tmo = 1'b0;
  logic [31:0] exp_eaddr = '0;
  always #5 clk = ~clk;
  nmi_xbar_demux_if #(.N(1)) mif ();
  nmi_xbar_demux_if #(.N(N)) sif ();
  nmi_xbar_demux #(
    .SLV_NUM(N), .ADDR_BASE(BASE), .ADDR_MASK(MASK), .TMO_CYCLES(TMO), .ERR_RDATA(ERRD)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .m(mif), .s(sif),
    .err_clr_i(err_clr), .err_o(err), .err_tmo_o(err_tmo), .err_addr_o(err_addr)
  );
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & win_mask[i]) == win_base[i]) return i;
    return -1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic chk_err();
    chk("err_o", 32'(err), 32'(exp_err));
    chk("err_tmo", 32'(err_tmo), 32'(exp_tmo));
    chk("err_addr", err_addr, exp_eaddr);
  endtask
  // One request: slave readies after dly of its own valid cycles (dly >= TMO means never).
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input int dly, input logic [31:0] data, input logic clr);
    int idx, lat, vcyc, cnt, e_lat, e_vcyc;
    logic [3:0] vor, e_vor;
    logic [31:0] rd, e_rd;
    idx = decode(a);
    if (clr) exp_err = 1'b0;
    if (idx < 0) begin
      e_lat = 2; e_rd = ERRD; e_vor = '0; e_vcyc = 0;
      exp_err = 1'b1; exp_tmo = 1'b0; exp_eaddr = a;
    end else if (dly < TMO) begin
      e_lat = dly + 2; e_rd = data; e_vor = 4'(1 << idx); e_vcyc = dly + 1;
    end else begin
      e_lat = TMO + 2; e_rd = ERRD; e_vor = 4'(1 << idx); e_vcyc = TMO;
      exp_err = 1'b1; exp_tmo = 1'b1; exp_eaddr = a;
    end
    @(posedge clk) #1;
    mif.valid = 1'b1; mif.addr = a; mif.wdata = wd; mif.wstrb = ws; err_clr = clr;
    for (int i = 0; i < N; i++) sif.rdata[32*i +: 32] = (i == idx) ? data : ~data ^ 32'(i);
    cnt = 0; lat = -1; vcyc = 0; vor = '0; rd = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      sif.ready = (cnt == dly) ? sif.valid : '0;
      @(negedge clk);
      if (k == 1) begin
        chk("pass_addr", sif.addr, a);
        chk("pass_wdata", sif.wdata, wd);
        chk("pass_wstrb", 32'(sif.wstrb), 32'(ws));
      end
      vor |= sif.valid;
      if (|sif.valid) begin vcyc++; cnt++; end
      if (mif.ready) begin lat = k; rd = mif.rdata; end
      @(posedge clk) #1;
    end
    mif.valid = 1'b0; sif.ready = '0; err_clr = 1'b0;
    @(negedge clk);
    chk("latency", 32'(lat), 32'(e_lat));
    chk("rdata", rd, e_rd);
    chk("svalid_seen", 32'(vor), 32'(e_vor));
    chk("svalid_cycles", 32'(vcyc), 32'(e_vcyc));
    chk("ready_idle", 32'(mif.ready), 32'h0);
    chk_err();
  endtask
  initial begin
    logic [31:0] a;
    int r, dly;
    mif.valid = 1'b0; mif.addr = '0; mif.wdata = '0; mif.wstrb = '0;
    sif.ready = '0; sif.rdata = '0;
    #12;
    chk("rst_svalid", 32'(sif.valid), 32'h0);
    chk("rst_ready", 32'(mif.ready), 32'h0);
    chk("rst_rdata", mif.rdata, 32'h0);
    chk_err();
    @(posedge clk) #1 rst_n = 1'b1;
    txn(32'h1000_0304, 32'h0, 4'h0, 2, 32'h1234_5678, 1'b0);
    txn(32'h9000_0000, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b0);
    txn(32'h2000_0104, 32'h0, 4'h0, 1000, 32'h0BAD_F00D, 1'b0);
    @(posedge clk) #1 err_clr = 1'b1;
    @(posedge clk) #1 err_clr = 1'b0;
    exp_err = 1'b0;
    @(negedge clk) chk_err();
    txn(32'h1000_0000, 32'hCAFE_0001, 4'hF, 1, 32'h0000_0011, 1'b0);
    txn(32'h1000_0304, 32'h0, 4'h0, TMO - 1, 32'h7777_0007, 1'b0);
    txn(32'h2000_0100, 32'h0, 4'h0, TMO, 32'h8888_0008, 1'b0);
    txn(32'h3000_0040, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    @(posedge clk) #1;
    mif.valid = 1'b1; mif.addr = 32'h2000_0100; mif.wstrb = 4'h0; sif.ready = '0;
    repeat (3) @(posedge clk);
    #1 mif.valid = 1'b0;
    #1;
    chk("drop_svalid", 32'(sif.valid), 32'h0);
    chk("drop_ready", 32'(mif.ready), 32'h0);
    @(negedge clk) chk_err();
    txn(32'h1000_0310, 32'h0, 4'h0, 0, 32'h0000_3333, 1'b0);
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 4);
      a = $urandom;
      a = (r == 0) ? ((a & ~32'hF000_FF00) | 32'h1000_0000)
        : (r == 1) ? ((a & ~32'hF000_FF00) | 32'h2000_0100)
        : (r == 2) ? ((a & ~32'hF000_FF00) | 32'h1000_0300)
        : (r == 3) ? ((a & ~32'hF000_FF00) | 32'h1000_0500) : a;
      r = $urandom_range(0, 9);
      dly = (r < 7) ? r % 4 : (r == 7) ? TMO - 1 : (r == 8) ? TMO : 1000;
      txn(a, $urandom, 4'($urandom), dly, $urandom, $urandom_range(0, 3) == 0);
    end
    txn(32'h7000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    @(posedge clk) #1;
    mif.valid = 1'b1; mif.addr = 32'h2000_0100; sif.ready = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    exp_err = 1'b0; exp_tmo = 1'b0; exp_eaddr = '0;
    chk("mrst_svalid", 32'(sif.valid), 32'h0);
    chk("mrst_ready", 32'(mif.ready), 32'h0);
    chk("mrst_rdata", mif.rdata, 32'h0);
    chk_err();
    mif.valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    txn(32'h1000_0000, 32'h0, 4'h0, 0, 32'h4242_4242, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
